uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side timing and control stage for the UART receiver. It sits directly upstream of the 9-bit receive shift register (8 data bits plus stop bit) and drives that register's shift strobe. It also consumes the register's stop_bit output to qualify the frame, then signals the downstream receive buffer to load. Contains the input synchronizer, start-edge detector, bit-period timer and frame FSM.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; legal range 4..255.
NUM_BITS, 9, shift strobes per frame (8 data bits plus 1 stop bit); legal range 2..16.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  reset; synchronous, active-low.
serial_in  input  1  asynchronous serial line; idles high.
stop_bit  input  1  stop bit from the shift register; valid the cycle after the last shift_strobe.
serial_sync  output  1  2-flop-synchronized serial_in; the shift register shifts this signal in.
shift_strobe  output  1  one-cycle pulse at mid-bit; shift_enable for the shift register.
load_buffer  output  1  one-cycle pulse when a valid frame completes.
framing_error  output  1  sticky flag: last frame's stop bit was 0.
busy  output  1  high from start detection until the FSM returns to IDLE.

Behaviour:
- Reset (n_rst low at a rising clk edge):
  - Both sync flops, and the edge-history flop, go to 1.
  - FSM goes to IDLE; timer and bit count go to 0.
  - shift_strobe, load_buffer, framing_error and busy go to 0.
  - Reset mid-frame abandons the frame silently; no load, no error.
- Synchronizer: serial_sync equals serial_in delayed by 2 clk edges. start_edge = prev & ~serial_sync, where prev is serial_sync delayed by 1 cycle and is updated every cycle.
- T0 is the cycle in which start_edge is high while the FSM is in IDLE.
- FSM states:
  - IDLE: busy=0. On start_edge, clear the timer and bit count and go to RECEIVE. Clear framing_error at the same edge.
  - RECEIVE: busy=1. The timer counts clk cycles since T0.
    - shift_strobe is high for exactly one cycle at T0 + k*CLKS_PER_BIT + CLKS_PER_BIT/2, for k = 1..NUM_BITS (integer division).
    - The cycle after strobe NUM_BITS, go to STOP_CHK.
  - STOP_CHK: busy=1, one cycle; stop_bit is sampled here.
    - stop_bit=1: go to LOAD.
    - stop_bit=0: set framing_error, go to IDLE (no load).
  - LOAD: busy=1, one cycle; load_buffer=1, then go to IDLE.
- Timing: the last strobe is at Tlast. STOP_CHK is at Tlast+1. load_buffer, or the framing_error rise, appears at Tlast+2. The FSM is in IDLE at Tlast+3 at the latest.
- start_edge is ignored outside IDLE. A falling edge whose start_edge cycle lands in STOP_CHK or LOAD is lost.
- serial_in activity between strobes has no effect.
- Timer width is $clog2((NUM_BITS+1)*CLKS_PER_BIT+1) bits; it never wraps within a frame.
- framing_error holds until the next accepted start_edge or reset.
- No output is combinational from serial_in.

Optional Feature:
Macro START_VALIDATE_EN.
- Defined: add a START_CHK state between IDLE and RECEIVE. At T0 + CLKS_PER_BIT/2, sample serial_sync.
  - If serial_sync=1 (glitch): return to IDLE with no strobes. framing_error keeps its value from before the glitch, and busy drops the next cycle.
  - If serial_sync=0: continue in RECEIVE. The strobe timing above is unchanged.
- Undefined: no start-bit check; any accepted start_edge starts a full frame.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state enum: IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD;
  - default constants: CLKS_PER_BIT_DEF = 10, NUM_BITS_DEF = 9.
- One sub-module, rx_bit_timer: a loadable up-counter with clear and enable that produces the mid-bit strobe and the bit count.
- Synchronizer and FSM stay in uart_rx_ctrl.

Test Plan:
All scenarios use CLKS_PER_BIT=10 and NUM_BITS=9.
1. Reset: hold n_rst low 2 cycles with serial_in=0 -> all outputs 0, serial_sync=1; after release with serial_in=1, no strobe for 200 cycles.
2. Good frame: send 0x A5 LSB-first with stop=1, and drive stop_bit=1 at Tlast+1 -> shift_strobe at T0+15, 25, …, 95 (9 pulses); load_buffer at T0+97 only; framing_error=0; busy high T0..T0+97.
3. Framing error: same frame with stop_bit=0 at T0+96 -> framing_error=1 at T0+97, no load_buffer; the next valid frame clears framing_error at its T0.
4. Back-to-back: a second start edge 1 bit period after the first frame's stop-bit midpoint -> second frame accepted, 9 strobes, second load_buffer.
5. Reset mid-frame: assert n_rst at T0+40 -> no further strobes, busy=0, no load or error; the next frame works normally.
6. Glitch, with START_VALIDATE_EN defined: serial_in low for 3 cycles -> no shift_strobe, busy drops at T0+6, framing_error unchanged. With the macro undefined, the same glitch produces 9 strobes.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receive-controller state encoding and default timing parameters
//   IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD : frame FSM states
//   CLKS_PER_BIT_DEF, NUM_BITS_DEF           : default bit period and strobes per frame
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD} rx_state_e;
    localparam int CLKS_PER_BIT_DEF = 10;
    localparam int NUM_BITS_DEF = 9;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line, shift-register handshake and status of the receive controller
//   serial_in, stop_bit                                      : into the controller
//   serial_sync, shift_strobe, load_buffer, framing_error, busy : out of the controller
interface uart_rx_ctrl_if;
    logic serial_in;
    logic stop_bit;
    logic serial_sync;
    logic shift_strobe;
    logic load_buffer;
    logic framing_error;
    logic busy;
    modport master (
        output serial_in, stop_bit,
        input  serial_sync, shift_strobe, load_buffer, framing_error, busy
    );
    modport slave (
        input  serial_in, stop_bit,
        output serial_sync, shift_strobe, load_buffer, framing_error, busy
    );
endinterface

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: cycle counter since start detection with bit-midpoint strobe and bit index
//   clk, n_rst : clock, synchronous active-low reset
//   clr_i      : zero the counter (held while idle)
//   ld_i       : start a frame; counter reads 1 in the cycle after start detection
//   en_i       : advance the counter
//   strobe_o   : one-cycle pulse at every bit midpoint, start bit included
//   bit_cnt_o  : index of the bit that strobe_o marks (0 = start bit)
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int NUM_BITS = NUM_BITS_DEF,
    localparam int TW = $clog2((NUM_BITS + 1) * CLKS_PER_BIT + 1),
    localparam int BW = $clog2(NUM_BITS + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic          en_i,
    output logic          strobe_o,
    output logic [BW-1:0] bit_cnt_o
);
    logic [TW-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          strobe_q, strobe_d, step;
    // tgt_q holds the next midpoint; the strobe is registered, so match one cycle early
    assign step = en_i && cnt_q + TW'(1) == tgt_q;
    assign strobe_o = strobe_q;
    assign bit_cnt_o = bit_cnt_q;
    // bit count loads all-ones so the start-bit midpoint wraps it to 0
    always_comb begin
        cnt_d     = ld_i ? TW'(1) : clr_i ? '0 : en_i ? cnt_q + TW'(1) : cnt_q;
        tgt_d     = ld_i ? TW'(CLKS_PER_BIT / 2) : clr_i ? '0 : step ? tgt_q + TW'(CLKS_PER_BIT) : tgt_q;
        bit_cnt_d = ld_i ? '1 : clr_i ? '0 : step ? bit_cnt_q + BW'(1) : bit_cnt_q;
        strobe_d  = !ld_i && !clr_i && step;
    end
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q     <= '0;
            tgt_q     <= '0;
            bit_cnt_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            bit_cnt_q <= bit_cnt_d;
            strobe_q  <= strobe_d;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive synchronizer, start detector, bit timer and frame FSM
//   clk, n_rst : clock, synchronous active-low reset
//   bus        : uart_rx_ctrl_if.slave (serial_in, stop_bit in; serial_sync, shift_strobe,
//                load_buffer, framing_error, busy out)
//   START_VALIDATE_EN : when defined, the start bit is re-sampled at its midpoint and a
//                       short low glitch returns to IDLE without strobes
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int NUM_BITS = NUM_BITS_DEF
) (
    input logic           clk,
    input logic           n_rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int BW = $clog2(NUM_BITS + 1);
    rx_state_e     state_q;
    logic          sync1_q, sync2_q, prev_q, load_q, ferr_q, accept, mid;
    logic [BW-1:0] bit_cnt;
    assign accept = state_q == IDLE && prev_q && !sync2_q;
    assign bus.serial_sync = sync2_q;
    // bit 0 is the start bit; only data/stop midpoints reach the shift register
    assign bus.shift_strobe = mid && bit_cnt != '0;
    assign bus.load_buffer = load_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy = state_q != IDLE || accept;
    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .NUM_BITS(NUM_BITS)) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr_i     (state_q == IDLE && !accept),
        .ld_i      (accept),
        .en_i      (state_q == START_CHK || state_q == RECEIVE),
        .strobe_o  (mid),
        .bit_cnt_o (bit_cnt)
    );
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            {sync1_q, sync2_q, prev_q} <= '1;
            state_q <= IDLE;
            load_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= bus.serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            load_q  <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
`ifdef START_VALIDATE_EN
                    state_q <= START_CHK;
`else
                    state_q <= RECEIVE;
                    ferr_q  <= 1'b0;
`endif
                end
                // a glitch keeps the previous error flag; a real start bit clears it
                START_CHK: if (mid) begin
                    state_q <= sync2_q ? IDLE : RECEIVE;
                    ferr_q  <= ferr_q && sync2_q;
                end
                RECEIVE: if (mid && bit_cnt == BW'(NUM_BITS)) state_q <= STOP_CHK;
                STOP_CHK: begin
                    state_q <= bus.stop_bit ? LOAD : IDLE;
                    load_q  <= bus.stop_bit;
                    ferr_q  <= !bus.stop_bit;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl (CLKS_PER_BIT=10, NUM_BITS=9)
module tb_uart_rx_ctrl;
    localparam int C = 10;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic fe_prev = 1'b0;
    int cyc = 0;
    int n_pass = 0;
    int n_chk = 0;
    int t0, t0b;
    int strb[$], lds[$], bsy[$], fe_up[$], fe_dn[$];
    uart_rx_ctrl_if bus();
    uart_rx_ctrl #(.CLKS_PER_BIT(C), .NUM_BITS(9)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.shift_strobe) strb.push_back(cyc);
        if (bus.load_buffer) lds.push_back(cyc);
        if (bus.busy) bsy.push_back(cyc);
        if (bus.framing_error && !fe_prev) fe_up.push_back(cyc);
        if (!bus.framing_error && fe_prev) fe_dn.push_back(cyc);
        fe_prev <= bus.framing_error;
    end
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic clear_q;
        strb.delete();
        lds.delete();
        bsy.delete();
        fe_up.delete();
        fe_dn.delete();
    endtask
    // start bit, 8 data bits LSB first, stop bit 1; start_edge lands two cycles after the drop
    task automatic send(input logic [7:0] d, output int t);
        bus.serial_in = 1'b0;
        t = cyc + 2;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            bus.serial_in = d[i];
            tick(C);
        end
        bus.serial_in = 1'b1;
        tick(C);
    endtask
    // frame n in the queues: strobes at T0+15,25..95, load at T0+97
    task automatic chk_frame(input string tag, input int t, input int n);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s strobe%0d", tag, k + 1),
                  9 * n + k < strb.size() ? strb[9 * n + k] - t : -1, 15 + 10 * k);
        check({tag, " load"}, n < lds.size() ? lds[n] - t : -1, 97);
    endtask
    initial begin
        bus.serial_in = 1'b0;
        bus.stop_bit = 1'b1;
        tick(2);
        check("rst serial_sync", bus.serial_sync, 1);
        check("rst shift_strobe", bus.shift_strobe, 0);
        check("rst load_buffer", bus.load_buffer, 0);
        check("rst framing_error", bus.framing_error, 0);
        check("rst busy", bus.busy, 0);
        bus.serial_in = 1'b1;
        n_rst = 1'b1;
        clear_q();
        tick(200);
        check("idle strobes", strb.size(), 0);
        check("idle busy", bsy.size(), 0);

        clear_q();
        send(8'hA5, t0);
        tick(5);
        check("good strobe count", strb.size(), 9);
        check("good load count", lds.size(), 1);
        chk_frame("good", t0, 0);
        check("good busy cycles", bsy.size(), 98);
        check("good busy first", bsy.size() > 0 ? bsy[0] - t0 : -1, 0);
        check("good busy last", bsy.size() > 0 ? bsy[bsy.size() - 1] - t0 : -1, 97);
        check("good framing_error", bus.framing_error, 0);

        bus.stop_bit = 1'b0;
        clear_q();
        send(8'hA5, t0);
        tick(5);
        check("ferr strobe count", strb.size(), 9);
        check("ferr load count", lds.size(), 0);
        check("ferr rise", fe_up.size() > 0 ? fe_up[0] - t0 : -1, 97);
        check("ferr busy last", bsy.size() > 0 ? bsy[bsy.size() - 1] - t0 : -1, 96);
        check("ferr held", bus.framing_error, 1);
        bus.stop_bit = 1'b1;
        clear_q();
        send(8'h3C, t0);
        tick(5);
        chk_frame("recover", t0, 0);
`ifdef START_VALIDATE_EN
        check("ferr clear", fe_dn.size() > 0 ? fe_dn[0] - t0 : -1, 6);
`else
        check("ferr clear", fe_dn.size() > 0 ? fe_dn[0] - t0 : -1, 1);
`endif
        check("recover framing_error", bus.framing_error, 0);

        clear_q();
        send(8'h0F, t0);
        tick(5);
        send(8'hF0, t0b);
        tick(5);
        check("b2b strobe count", strb.size(), 18);
        check("b2b load count", lds.size(), 2);
        chk_frame("b2b first", t0, 0);
        chk_frame("b2b second", t0b, 1);

        clear_q();
        bus.serial_in = 1'b0;
        t0 = cyc + 2;
        tick(C);
        bus.serial_in = 1'b1;
        tick(32);
        check("midrst strobes before", strb.size(), 3);
        n_rst = 1'b0;
        tick(1);
        clear_q();
        tick(1);
        n_rst = 1'b1;
        tick(100);
        check("midrst strobes after", strb.size(), 0);
        check("midrst load", lds.size(), 0);
        check("midrst ferr", fe_up.size(), 0);
        check("midrst busy", bsy.size(), 0);
        clear_q();
        send(8'h5A, t0);
        tick(5);
        chk_frame("after rst", t0, 0);

        bus.stop_bit = 1'b0;
        send(8'h81, t0);
        tick(5);
        bus.stop_bit = 1'b1;
        clear_q();
        bus.serial_in = 1'b0;
        t0 = cyc + 2;
        tick(3);
        bus.serial_in = 1'b1;
        tick(110);
`ifdef START_VALIDATE_EN
        check("glitch strobes", strb.size(), 0);
        check("glitch load", lds.size(), 0);
        check("glitch busy cycles", bsy.size(), 6);
        check("glitch busy last", bsy.size() > 0 ? bsy[bsy.size() - 1] - t0 : -1, 5);
        check("glitch framing_error", bus.framing_error, 1);
`else
        check("glitch strobes", strb.size(), 9);
        chk_frame("glitch", t0, 0);
        check("glitch framing_error", bus.framing_error, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
